// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Holds the opcode match patterns, ALU/transfer codes and the decoded-op class.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_ILLEGAL,
    OP_ADDI,
    OP_ADDS,
    OP_SUBS,
    OP_MOVZ,
    OP_MOVK,
    OP_LDUR,
    OP_LDURB,
    OP_STUR,
    OP_STURB,
    OP_B,
    OP_CBZ,
    OP_BLT
  } op_t;

  localparam logic [9:0]  OPC_ADDI  = 10'b1001000100;
  localparam logic [10:0] OPC_ADDS  = 11'b10101011000;
  localparam logic [10:0] OPC_SUBS  = 11'b11101011000;
  localparam logic [8:0]  OPC_MOVZ  = 9'b110100101;
  localparam logic [8:0]  OPC_MOVK  = 9'b111100101;
  localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
  localparam logic [10:0] OPC_LDURB = 11'b00111000010;
  localparam logic [10:0] OPC_STUR  = 11'b11111000000;
  localparam logic [10:0] OPC_STURB = 11'b00111000000;
  localparam logic [5:0]  OPC_B     = 6'b000101;
  localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
  localparam logic [7:0]  OPC_BCOND = 8'b01010100;
  localparam logic [4:0]  COND_LT   = 5'b01011;

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;

  localparam logic [3:0] XFER_DWORD = 4'd8;
  localparam logic [3:0] XFER_BYTE  = 4'd1;

  // opc is instr[31:21], cond is instr[4:0]
  function automatic op_t decode_op(input logic [10:0] opc, input logic [4:0] cond);
    op_t op;
    op = OP_ILLEGAL;
    if (opc[10:1] == OPC_ADDI)                         op = OP_ADDI;
    else if (opc == OPC_ADDS)                          op = OP_ADDS;
    else if (opc == OPC_SUBS)                          op = OP_SUBS;
    else if (opc[10:2] == OPC_MOVZ)                    op = OP_MOVZ;
    else if (opc[10:2] == OPC_MOVK)                    op = OP_MOVK;
    else if (opc == OPC_LDUR)                          op = OP_LDUR;
    else if (opc == OPC_LDURB)                         op = OP_LDURB;
    else if (opc == OPC_STUR)                          op = OP_STUR;
    else if (opc == OPC_STURB)                         op = OP_STURB;
    else if (opc[10:5] == OPC_B)                       op = OP_B;
    else if (opc[10:3] == OPC_CBZ)                     op = OP_CBZ;
    else if (opc[10:3] == OPC_BCOND && cond == COND_LT) op = OP_BLT;
    return op;
  endfunction

  function automatic logic is_mem_op(input op_t op);
    return (op == OP_LDUR) || (op == OP_LDURB) || (op == OP_STUR) || (op == OP_STURB);
  endfunction

  function automatic logic is_store_op(input op_t op);
    return (op == OP_STUR) || (op == OP_STURB);
  endfunction

  function automatic logic is_byte_op(input op_t op);
    return (op == OP_LDURB) || (op == OP_STURB);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Fetch port, datapath condition inputs and datapath control outputs of the controller.
// master = control unit, slave = instruction memory / datapath side.
interface multicycle_ctrl_if;
  logic [63:0] pc;
  logic        fetch_req;
  logic        instr_valid;
  logic [31:0] instr_in;
  logic [31:0] instruction;

  logic        negative;
  logic        zero;
  logic        overflow;
  logic        carry_out;
  logic        zSet;

  logic        Reg2Loc;
  logic        ALUSrc;
  logic        MemToReg;
  logic        RegWrite;
  logic        MemWrite;
  logic        read_en;
  logic        BrTaken;
  logic        UncondBr;
  logic        movz;
  logic        movk;
  logic        setFlag;
  logic        addi;
  logic        isLDURB;
  logic [2:0]  ALUOp;
  logic [3:0]  xfer_size;
  logic        illegal;

  modport master (
    output pc, fetch_req, instruction,
    output Reg2Loc, ALUSrc, MemToReg, RegWrite, MemWrite, read_en, BrTaken, UncondBr,
    output movz, movk, setFlag, addi, isLDURB, ALUOp, xfer_size, illegal,
    input  instr_valid, instr_in, negative, zero, overflow, carry_out, zSet
  );

  modport slave (
    input  pc, fetch_req, instruction,
    input  Reg2Loc, ALUSrc, MemToReg, RegWrite, MemWrite, read_en, BrTaken, UncondBr,
    input  movz, movk, setFlag, addi, isLDURB, ALUOp, xfer_size, illegal,
    output instr_valid, instr_in, negative, zero, overflow, carry_out, zSet
  );
endinterface

// File: rtl/multicycle_ctrl_pc_unit.sv
// Program counter: holds the PC and selects pc+4 or a PC-relative branch target.
// uncond picks the 26-bit B offset, otherwise the 19-bit conditional offset.
module pc_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic        take,
  input  logic        uncond,
  input  logic [25:0] i_imm,
  output logic [63:0] o_pc
);

  logic [63:0] r_pc;
  logic [63:0] w_off26;
  logic [63:0] w_off19;
  logic [63:0] w_pc_nxt;

  assign w_off26 = {{36{i_imm[25]}}, i_imm[25:0], 2'b00};
  assign w_off19 = {{43{i_imm[23]}}, i_imm[23:5], 2'b00};

  always_comb begin
    w_pc_nxt = r_pc + 64'd4;
    if (take) begin
      w_pc_nxt = r_pc + (uncond ? w_off26 : w_off19);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (advance) begin
      r_pc <= w_pc_nxt;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: fetches over a valid handshake, latches the word and
// sequences datapath controls per state; branches resolve from datapath flags.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_FETCH | fetch_req high, wait for instr_valid and latch the word
//   S_EXEC  | decode; ALU/MOV/branch finish here, memory ops form address
//   S_MEM   | memory access; stores finish here
//   S_WB    | load write-back
//   S_HALT  | undecodable word executed; all controls low until reset
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_instr;
  logic        r_illegal;
  op_t         w_op;

  logic        w_fetch_req;
  logic        w_reg2loc;
  logic        w_alu_src;
  logic        w_mem_to_reg;
  logic        w_reg_write;
  logic        w_mem_write;
  logic        w_read_en;
  logic        w_br_taken;
  logic        w_uncond_br;
  logic        w_movz;
  logic        w_movk;
  logic        w_set_flag;
  logic        w_addi;
  logic        w_is_ldurb;
  logic [2:0]  w_alu_op;
  logic [3:0]  w_xfer_size;
  logic        w_advance;
  logic        w_take;
  logic        w_set_illegal;
  logic        w_unused;

  assign w_op = decode_op(r_instr[31:21], r_instr[4:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_instr   <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_FETCH && bus.instr_valid) begin
        r_instr <= bus.instr_in;
      end
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_fetch_req   = 1'b0;
    w_reg2loc     = 1'b0;
    w_alu_src     = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_reg_write   = 1'b0;
    w_mem_write   = 1'b0;
    w_read_en     = 1'b0;
    w_br_taken    = 1'b0;
    w_uncond_br   = 1'b0;
    w_movz        = 1'b0;
    w_movk        = 1'b0;
    w_set_flag    = 1'b0;
    w_addi        = 1'b0;
    w_is_ldurb    = 1'b0;
    w_alu_op      = ALU_PASS_B;
    w_xfer_size   = XFER_DWORD;
    w_advance     = 1'b0;
    w_take        = 1'b0;
    w_set_illegal = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_fetch_req = 1'b1;
        if (bus.instr_valid) begin
          w_state_nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        w_advance   = 1'b1;
        w_state_nxt = S_FETCH;
        case (w_op)
          OP_ADDI: begin
            w_alu_src   = 1'b1;
            w_addi      = 1'b1;
            w_alu_op    = ALU_ADD;
            w_reg_write = 1'b1;
          end
          OP_ADDS, OP_SUBS: begin
            w_reg2loc   = 1'b1;
            w_alu_op    = (w_op == OP_SUBS) ? ALU_SUB : ALU_ADD;
            w_reg_write = 1'b1;
            w_set_flag  = 1'b1;
          end
          OP_MOVZ, OP_MOVK: begin
            w_alu_src   = 1'b1;
            w_reg_write = 1'b1;
            w_movz      = (w_op == OP_MOVZ);
            w_movk      = (w_op == OP_MOVK);
          end
          OP_LDUR, OP_LDURB, OP_STUR, OP_STURB: begin
            w_alu_src   = 1'b1;
            w_alu_op    = ALU_ADD;
            w_advance   = 1'b0;
            w_state_nxt = S_MEM;
          end
          OP_B: begin
            w_uncond_br = 1'b1;
            w_br_taken  = 1'b1;
            w_take      = 1'b1;
          end
          OP_CBZ: begin
            w_take     = bus.zSet;
            w_br_taken = bus.zSet;
          end
          OP_BLT: begin
            w_take     = bus.negative ^ bus.overflow;
            w_br_taken = bus.negative ^ bus.overflow;
          end
          default: begin
            w_advance     = 1'b0;
            w_set_illegal = 1'b1;
            w_state_nxt   = S_HALT;
          end
        endcase
      end

      S_MEM: begin
        w_alu_src = 1'b1;
        w_alu_op  = ALU_ADD;
        if (is_byte_op(w_op)) begin
          w_xfer_size = XFER_BYTE;
        end
        if (is_store_op(w_op)) begin
          w_mem_write = 1'b1;
          w_advance   = 1'b1;
          w_state_nxt = S_FETCH;
        end else begin
          w_read_en   = 1'b1;
          w_state_nxt = S_WB;
        end
      end

      S_WB: begin
        w_alu_src    = 1'b1;
        w_alu_op     = ALU_ADD;
        w_read_en    = 1'b1;
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_is_ldurb   = (w_op == OP_LDURB);
        if (is_byte_op(w_op)) begin
          w_xfer_size = XFER_BYTE;
        end
        w_advance   = 1'b1;
        w_state_nxt = S_FETCH;
      end

      S_HALT: begin
        w_state_nxt = S_HALT;
      end

      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  pc_unit #(
    .RESET_PC(RESET_PC)
  ) u_pc_unit (
    .clk    (clk),
    .reset  (reset),
    .advance(w_advance),
    .take   (w_take),
    .uncond (w_uncond_br),
    .i_imm  (r_instr[25:0]),
    .o_pc   (bus.pc)
  );

  // Write strobes drop in the same cycle reset is raised so an aborted store never lands.
  assign bus.RegWrite    = w_reg_write & ~reset;
  assign bus.MemWrite    = w_mem_write & ~reset;
  assign bus.setFlag     = w_set_flag & ~reset;

  assign bus.fetch_req   = w_fetch_req;
  assign bus.instruction = r_instr;
  assign bus.illegal     = r_illegal;
  assign bus.Reg2Loc     = w_reg2loc;
  assign bus.ALUSrc      = w_alu_src;
  assign bus.MemToReg    = w_mem_to_reg;
  assign bus.read_en     = w_read_en;
  assign bus.BrTaken     = w_br_taken;
  assign bus.UncondBr    = w_uncond_br;
  assign bus.movz        = w_movz;
  assign bus.movk        = w_movk;
  assign bus.addi        = w_addi;
  assign bus.isLDURB     = w_is_ldurb;
  assign bus.ALUOp       = w_alu_op;
  assign bus.xfer_size   = w_xfer_size;

  // zero/carry_out are part of the datapath flag bundle but no supported branch uses them.
  assign w_unused = bus.zero ^ bus.carry_out;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: hand sequences for the multi-cycle cases
// plus a table of single-EXEC instructions with hand-computed controls and PC.
module tb_multicycle_ctrl;
  import cpu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.RESET_PC(64'h0)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // {Reg2Loc,ALUSrc,MemToReg,RegWrite,MemWrite,read_en,BrTaken,UncondBr,movz,movk,setFlag,addi,isLDURB}
  localparam logic [12:0] C_NONE = 13'b0_0_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [12:0] C_ADDI = 13'b0_1_0_1_0_0_0_0_0_0_0_1_0;
  localparam logic [12:0] C_FLAG = 13'b1_0_0_1_0_0_0_0_0_0_1_0_0;
  localparam logic [12:0] C_MOVZ = 13'b0_1_0_1_0_0_0_0_1_0_0_0_0;
  localparam logic [12:0] C_MOVK = 13'b0_1_0_1_0_0_0_0_0_1_0_0_0;
  localparam logic [12:0] C_BR   = 13'b0_0_0_0_0_0_1_0_0_0_0_0_0;
  localparam logic [12:0] C_B    = 13'b0_0_0_0_0_0_1_1_0_0_0_0_0;

  typedef struct {
    logic [31:0] instr;
    logic        n;
    logic        v;
    logic        z;
    logic [12:0] ctl;
    logic [2:0]  alu;
    longint      delta;
  } vec_t;

  vec_t        vecs[12];
  logic [63:0] pc_exp;
  int          nreq;
  int          cnt_a;
  int          cnt_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] ctl();
    return {bus.Reg2Loc, bus.ALUSrc, bus.MemToReg, bus.RegWrite, bus.MemWrite, bus.read_en,
            bus.BrTaken, bus.UncondBr, bus.movz, bus.movk, bus.setFlag, bus.addi, bus.isLDURB};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 2 time units into the EXEC cycle of word w.
  task automatic fetch_word(input logic [31:0] w, input int wait_cyc, output int req_cycles);
    req_cycles = 0;
    bus.instr_valid = 1'b0;
    bus.instr_in = 32'hDEAD_BEEF;
    for (int i = 0; i < wait_cyc; i++) begin
      #1;
      if (bus.fetch_req) req_cycles++;
      step();
    end
    bus.instr_in = w;
    bus.instr_valid = 1'b1;
    #1;
    if (bus.fetch_req) req_cycles++;
    step();
    bus.instr_valid = 1'b0;
    bus.instr_in = ~w;
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'hB4FFFFE0, 1'b0, 1'b0, 1'b1, C_BR,   3'b000, -64'sd4};
    vecs[1]  = '{32'h910017E1, 1'b0, 1'b0, 1'b0, C_ADDI, 3'b010, 64'sd4};
    vecs[2]  = '{32'hAB020020, 1'b0, 1'b0, 1'b0, C_FLAG, 3'b010, 64'sd4};
    vecs[3]  = '{32'hEB020020, 1'b0, 1'b0, 1'b0, C_FLAG, 3'b011, 64'sd4};
    vecs[4]  = '{32'hD28000A3, 1'b0, 1'b0, 1'b0, C_MOVZ, 3'b000, 64'sd4};
    vecs[5]  = '{32'hF2A00023, 1'b0, 1'b0, 1'b0, C_MOVK, 3'b000, 64'sd4};
    vecs[6]  = '{32'h54FFFFCB, 1'b0, 1'b0, 1'b0, C_NONE, 3'b000, 64'sd4};
    vecs[7]  = '{32'h54FFFFCB, 1'b0, 1'b1, 1'b0, C_BR,   3'b000, -64'sd8};
    vecs[8]  = '{32'h54FFFFCB, 1'b1, 1'b1, 1'b0, C_NONE, 3'b000, 64'sd4};
    vecs[9]  = '{32'hB4FFFFE0, 1'b0, 1'b0, 1'b0, C_NONE, 3'b000, 64'sd4};
    vecs[10] = '{32'h15FFFFFF, 1'b0, 1'b0, 1'b0, C_B,    3'b000, 64'sd134217724};
    vecs[11] = '{32'h16000000, 1'b0, 1'b0, 1'b0, C_B,    3'b000, -64'sd134217728};

    bus.instr_valid = 1'b0;
    bus.instr_in    = '0;
    bus.negative    = 1'b0;
    bus.zero        = 1'b0;
    bus.overflow    = 1'b0;
    bus.carry_out   = 1'b0;
    bus.zSet        = 1'b0;
    reset = 1'b1;
    step();
    step();

    check("rst_pc",        bus.pc, 64'h0);
    check("rst_fetch_req", 64'(bus.fetch_req), 64'd1);
    check("rst_instr",     64'(bus.instruction), 64'h0);
    check("rst_illegal",   64'(bus.illegal), 64'd0);
    check("rst_aluop",     64'(bus.ALUOp), 64'd0);
    check("rst_xfer",      64'(bus.xfer_size), 64'd8);
    check("rst_ctl",       64'(ctl()), 64'(C_NONE));
    reset = 1'b0;

    // ADDI X1,X31,#5 with the valid strobe three cycles late
    fetch_word(32'h910017E1, 3, nreq);
    check("addi_fetch_req_cycles", 64'(nreq), 64'd4);
    check("addi_latched", 64'(bus.instruction), 64'h910017E1);
    check("addi_ctl",     64'(ctl()), 64'(C_ADDI));
    check("addi_aluop",   64'(bus.ALUOp), 64'd2);
    check("addi_exec_fetch_req", 64'(bus.fetch_req), 64'd0);
    step();
    check("addi_pc", bus.pc, 64'd4);
    check("addi_rw_done", 64'(bus.RegWrite), 64'd0);

    // SUBS then B.LT -2 with N!=V
    fetch_word(32'hEB020020, 0, nreq);
    cnt_a = 0;
    if (bus.setFlag) cnt_a++;
    check("subs_aluop", 64'(bus.ALUOp), 64'd3);
    step();
    if (bus.setFlag) cnt_a++;
    check("subs_pc", bus.pc, 64'd8);
    bus.negative = 1'b1;
    bus.overflow = 1'b0;
    fetch_word(32'h54FFFFCB, 0, nreq);
    if (bus.setFlag) cnt_a++;
    check("subs_setflag_pulses", 64'(cnt_a), 64'd1);
    check("blt_brtaken", 64'(bus.BrTaken), 64'd1);
    check("blt_uncond",  64'(bus.UncondBr), 64'd0);
    step();
    check("blt_pc", bus.pc, 64'd0);
    bus.negative = 1'b0;

    // B +4 words to reach 16, then CBZ +3 taken / not taken
    fetch_word(32'h14000004, 0, nreq);
    check("b_ctl", 64'(ctl()), 64'(C_B));
    step();
    check("b_pc", bus.pc, 64'd16);
    bus.zSet = 1'b1;
    fetch_word(32'hB4000060, 0, nreq);
    check("cbz_t_brtaken", 64'(bus.BrTaken), 64'd1);
    step();
    bus.zSet = 1'b0;
    check("cbz_t_pc", bus.pc, 64'd28);
    fetch_word(32'h17FFFFFD, 0, nreq);
    step();
    check("b_back_pc", bus.pc, 64'd16);
    fetch_word(32'hB4000060, 0, nreq);
    check("cbz_nt_brtaken", 64'(bus.BrTaken), 64'd0);
    step();
    check("cbz_nt_pc", bus.pc, 64'd20);

    // LDURB: EXEC -> MEM -> WB, stray instr_valid mid-instruction ignored
    fetch_word(32'h38400041, 0, nreq);
    cnt_a = 0;
    cnt_b = 1;
    if (bus.RegWrite) cnt_a++;
    if (!bus.fetch_req) cnt_b++;
    check("ldurb_exec_alusrc", 64'(bus.ALUSrc), 64'd1);
    check("ldurb_exec_aluop",  64'(bus.ALUOp), 64'd2);
    check("ldurb_exec_rd",     64'(bus.read_en), 64'd0);
    step();
    bus.instr_valid = 1'b1;
    bus.instr_in = 32'hDEAD_BEEF;
    #1;
    if (bus.RegWrite) cnt_a++;
    if (!bus.fetch_req) cnt_b++;
    check("ldurb_mem_rd",   64'(bus.read_en), 64'd1);
    check("ldurb_mem_xfer", 64'(bus.xfer_size), 64'd1);
    check("ldurb_mem_m2r",  64'(bus.MemToReg), 64'd0);
    step();
    bus.instr_valid = 1'b0;
    #1;
    if (bus.RegWrite) cnt_a++;
    if (!bus.fetch_req) cnt_b++;
    check("ldurb_wb_ctl",   64'(ctl()), 64'(13'b0_1_1_1_0_1_0_0_0_0_0_0_1));
    check("ldurb_wb_xfer",  64'(bus.xfer_size), 64'd1);
    check("ldurb_hold_instr", 64'(bus.instruction), 64'h38400041);
    step();
    if (bus.RegWrite) cnt_a++;
    check("ldurb_rw_pulses", 64'(cnt_a), 64'd1);
    check("ldurb_cycles",    64'(cnt_b), 64'd4);
    check("ldurb_fetch_req", 64'(bus.fetch_req), 64'd1);
    check("ldurb_pc",        bus.pc, 64'd24);

    // STUR: one MemWrite cycle, no RegWrite
    fetch_word(32'hF8000041, 0, nreq);
    cnt_a = 0;
    cnt_b = 0;
    if (bus.MemWrite) cnt_a++;
    if (bus.RegWrite) cnt_b++;
    step();
    if (bus.MemWrite) cnt_a++;
    if (bus.RegWrite) cnt_b++;
    check("stur_mem_xfer",    64'(bus.xfer_size), 64'd8);
    check("stur_mem_reg2loc", 64'(bus.Reg2Loc), 64'd0);
    step();
    if (bus.MemWrite) cnt_a++;
    if (bus.RegWrite) cnt_b++;
    check("stur_mw_pulses", 64'(cnt_a), 64'd1);
    check("stur_rw_pulses", 64'(cnt_b), 64'd0);
    check("stur_pc",        bus.pc, 64'd28);

    // Second STUR aborted by reset raised in MEM
    fetch_word(32'hF8000041, 0, nreq);
    step();
    reset = 1'b1;
    #1;
    check("stur_abort_mw", 64'(bus.MemWrite), 64'd0);
    step();
    reset = 1'b0;
    #1;
    check("stur_abort_pc",    bus.pc, 64'h0);
    check("stur_abort_fetch", 64'(bus.fetch_req), 64'd1);
    check("stur_abort_mw2",   64'(bus.MemWrite), 64'd0);
    check("stur_abort_instr", 64'(bus.instruction), 64'h0);

    // Single-EXEC instruction table, starting at pc 0 (first entry wraps below zero)
    pc_exp = 64'h0;
    for (int i = 0; i < 12; i++) begin
      bus.negative = vecs[i].n;
      bus.overflow = vecs[i].v;
      bus.zSet     = vecs[i].z;
      fetch_word(vecs[i].instr, 0, nreq);
      check($sformatf("vec%0d_ctl", i),  64'(ctl()), 64'(vecs[i].ctl));
      check($sformatf("vec%0d_alu", i),  64'(bus.ALUOp), 64'(vecs[i].alu));
      check($sformatf("vec%0d_xfer", i), 64'(bus.xfer_size), 64'd8);
      step();
      bus.zSet = 1'b0;
      pc_exp = pc_exp + 64'(vecs[i].delta);
      check($sformatf("vec%0d_pc", i), bus.pc, pc_exp);
    end
    bus.negative = 1'b0;
    bus.overflow = 1'b0;

    // STURB byte store
    fetch_word(32'h38000041, 0, nreq);
    step();
    check("sturb_mw",   64'(bus.MemWrite), 64'd1);
    check("sturb_xfer", 64'(bus.xfer_size), 64'd1);
    step();
    pc_exp = pc_exp + 64'd4;
    check("sturb_pc", bus.pc, pc_exp);

    // Undecodable word: HALT until reset, fetch requests ignored
    fetch_word(32'h0000_0000, 0, nreq);
    step();
    bus.instr_valid = 1'b1;
    bus.instr_in = 32'h910017E1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("halt%0d_fetch_req", i), 64'(bus.fetch_req), 64'd0);
      check($sformatf("halt%0d_illegal", i),   64'(bus.illegal), 64'd1);
      check($sformatf("halt%0d_ctl", i),       64'(ctl()), 64'(C_NONE));
      check($sformatf("halt%0d_pc", i),        bus.pc, pc_exp);
      step();
    end
    bus.instr_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("post_halt_illegal",   64'(bus.illegal), 64'd0);
    check("post_halt_fetch_req", 64'(bus.fetch_req), 64'd1);
    check("post_halt_pc",        bus.pc, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
